vga_color_pipeline: RTL
=======================

# vga_color_pipeline

Parametrised raster timing generator and palette colour stage for the FFT visualiser. It counts pixels/lines for a configurable VGA mode and issues linear frame-buffer addresses to the bin BRAM. It maps each returned bin index through a double-buffered palette and emits delay-matched `hsync`/`vsync`/`video_out` to the VGA pins, compensating for a configurable memory read latency.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths in lines
- `BIN_W`, 3, bin index width; bins 1..2^BIN_W-1 have palette entries
- `COLOR_W`, 12, pixel width (4:4:4 RGB)
- `ADDR_W`, 19, frame-buffer address width; must hold H_ACTIVE*V_ACTIVE-1
- `MEM_LATENCY`, 2, cycles from `memory_addr` to valid `bin_data` (≥1)
- `video_clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ready`  in  1  frame buffer readable; low forces address 0 and black pixels
- `bin_data`  in  BIN_W  bin index from BRAM, MEM_LATENCY cycles after its address
- `palette_in`  in  (2^BIN_W-1)*COLOR_W  new palette; entry k (bin k+1) at bits [k*COLOR_W +: COLOR_W]
- `palette_valid`  in  1  `palette_in` offered
- `palette_ready`  out  1  shadow register free; transfer on valid&&ready
- `memory_addr`  out  ADDR_W  linear pixel address
- `hsync`, `vsync`  out  1 each  active-low sync
- `video_out`  out  COLOR_W  pixel colour, 0 outside active area
- `frame_start`  out  1  one-cycle pulse aligned with first active pixel on `video_out`

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. `hcount` 0..H_TOTAL-1 wraps; `vcount` increments at `hcount` wrap, 0..V_TOTAL-1 wraps.
- Raw active = hcount<H_ACTIVE && vcount<V_ACTIVE. Raw hsync low for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); raw vsync low for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), whole lines.
- Address: incremental counter (no multiplier); 0 at frame start, +1 per active pixel. `memory_addr` = counter when raw active && `ready`, else 0. Equals vcount*H_ACTIVE+hcount in active area.
- Bin 0 is always black; bin k≥1 returns active palette entry k-1.
- Palette handshake: accept on palette_valid && palette_ready into shadow, set pending, `palette_ready`=0. Commit shadow to active on the last cycle of the frame (hcount=H_TOTAL-1, vcount=V_TOTAL-1); clear pending. No mid-frame colour change. Valid on the commit cycle is not accepted (ready low); accepted next cycle.
- `ready` is sampled alongside raw active and delayed; pixel black if delayed ready is 0.

## Timing
- L = MEM_LATENCY+1. `bin_data` registered with its delayed active/ready flags at MEM_LATENCY; `video_out` registered one cycle later.
- `hsync`, `vsync`, active flag and `frame_start` delayed L cycles from raw counters, all registered; all outputs alignment-exact.
- Reset values: counters 0, address counter 0, `memory_addr` 0, `hsync`=1, `vsync`=1, `video_out`=0, `frame_start`=0, `palette_ready`=1, active palette and shadow all 0, delay lines cleared (inactive, sync high).
- Reset mid-frame: all state returns immediately to reset values; first frame after release starts at hcount=vcount=0.

## Configuration
- `VGA_COLOR_PIPELINE_TESTPATTERN_EN`: when defined, adds input `test_mode` (1 bit); when high, colour stage outputs 8 vertical bars, bar b = delayed hcount*8/H_ACTIVE, colour = {4{b[2]},4{b[1]},4{b[0]}} truncated to COLOR_W, ignoring `bin_data`/`ready`; blanking and syncs unchanged. Without it: port absent, bin lookup only.

## Structure
- Package `vga_timing_pkg`: default 640x480 timing constants, H_TOTAL/V_TOTAL functions, `color_t` (COLOR_W) typedef.
- Sub-module `vga_pipe_delay` (WIDTH, DEPTH, reset value parameter): shift register used for sync/active/ready/hcount alignment.

## Test plan
- Defaults, MEM_LATENCY=2: release reset -> `hsync` falls at cycle 659, rises at 755; `vsync` low for lines 490–491 only; period 800×525 cycles.
- `ready`=1 -> `memory_addr`=1285 at (h5,v2), 307199 at (h639,v479), 0 at h640 and throughout vertical blank.
- BRAM model returns bin 3, palette entry 2 = 0xF00 -> `video_out`=0xF00 3 cycles after address; bin 0 -> 0x000; blanking -> 0.
- Load palette at line 100 -> `palette_ready` low until frame-end commit, old colours until frame end, new colours from next `frame_start`; valid held on commit cycle accepted one cycle later.
- `ready` low for lines 10–20 -> `memory_addr`=0 and `video_out`=0 on those lines (delayed by 3), syncs unaffected.
- Assert `rst_n` low mid-line 200 -> outputs at reset values same cycle; `TESTPATTERN_EN` build with `test_mode`=1 -> pixel 80 shows bar 1 = 0x00F.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults, colour type and total-count helpers for the VGA colour pipeline.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_COLOR_W  = 12;

    typedef logic [DEF_COLOR_W-1:0] color_t;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// Fixed-depth shift register used to align raster flags with the memory read path.
module vga_pipe_delay #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             video_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_color_pipeline.sv
// Raster timing generator, frame-buffer addressing and double-buffered palette stage.
// Optional VGA_COLOR_PIPELINE_TESTPATTERN_EN adds a test_mode input selecting 8 vertical colour bars.
module vga_color_pipeline
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter int unsigned BIN_W       = 3,
    parameter int unsigned COLOR_W     = DEF_COLOR_W,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                                   video_clk,
    input  logic                                   rst_n,
    input  logic                                   ready,
    input  logic [BIN_W-1:0]                       bin_data,
    input  logic [((2**BIN_W)-1)*COLOR_W-1:0]      palette_in,
    input  logic                                   palette_valid,
`ifdef VGA_COLOR_PIPELINE_TESTPATTERN_EN
    input  logic                                   test_mode,
`endif
    output logic                                   palette_ready,
    output logic [ADDR_W-1:0]                      memory_addr,
    output logic                                   hsync,
    output logic                                   vsync,
    output logic [COLOR_W-1:0]                     video_out,
    output logic                                   frame_start
);

    localparam int unsigned H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned H_CNT_W  = $clog2(H_TOTAL);
    localparam int unsigned V_CNT_W  = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned OUT_LAT  = MEM_LATENCY + 1;
    localparam int unsigned NUM_ENT  = (2**BIN_W) - 1;

    logic [H_CNT_W-1:0] hcount;
    logic [V_CNT_W-1:0] vcount;
    logic [ADDR_W-1:0]  addr_cnt;
    logic               h_last;
    logic               frame_end;
    logic               raw_active;
    logic               raw_hsync;
    logic               raw_vsync;
    logic               raw_fs;

    assign h_last     = (hcount == H_CNT_W'(H_TOTAL - 1));
    assign frame_end  = h_last && (vcount == V_CNT_W'(V_TOTAL - 1));
    assign raw_active = (32'(hcount) < H_ACTIVE) && (32'(vcount) < V_ACTIVE);
    assign raw_hsync  = !((32'(hcount) >= HS_START) && (32'(hcount) < HS_END));
    assign raw_vsync  = !((32'(vcount) >= VS_START) && (32'(vcount) < VS_END));
    assign raw_fs     = (hcount == '0) && (vcount == '0);

    // Pixel/line counters plus an incremental linear address (no multiplier).
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount   <= '0;
            vcount   <= '0;
            addr_cnt <= '0;
        end else begin
            hcount <= h_last ? '0 : hcount + H_CNT_W'(1);
            if (h_last) vcount <= frame_end ? '0 : vcount + V_CNT_W'(1);
            if (frame_end)       addr_cnt <= '0;
            else if (raw_active) addr_cnt <= addr_cnt + ADDR_W'(1);
        end
    end

    assign memory_addr = (raw_active && ready) ? addr_cnt : '0;

    // Flags that must line up with bin_data arriving MEM_LATENCY cycles after its address.
    logic act_d;
    logic rdy_d;
`ifdef VGA_COLOR_PIPELINE_TESTPATTERN_EN
    localparam int unsigned PIPE_W = 3 + H_CNT_W;
    logic               tm_d;
    logic [H_CNT_W-1:0] hc_d;
    vga_pipe_delay #(.WIDTH(PIPE_W), .DEPTH(MEM_LATENCY), .RST_VAL('0)) u_mem_align (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .din       ({raw_active, ready, test_mode, hcount}),
        .dout      ({act_d, rdy_d, tm_d, hc_d})
    );
`else
    vga_pipe_delay #(.WIDTH(2), .DEPTH(MEM_LATENCY), .RST_VAL(2'b00)) u_mem_align (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .din       ({raw_active, ready}),
        .dout      ({act_d, rdy_d})
    );
`endif

    logic [2:0] sync_q;
    vga_pipe_delay #(.WIDTH(3), .DEPTH(OUT_LAT), .RST_VAL(3'b110)) u_sync_align (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .din       ({raw_hsync, raw_vsync, raw_fs}),
        .dout      (sync_q)
    );
    assign {hsync, vsync, frame_start} = sync_q;

    // Double-buffered palette: shadow loads any time, active swaps only on the last frame cycle.
    logic [COLOR_W-1:0] pal_act [NUM_ENT];
    logic [COLOR_W-1:0] pal_shd [NUM_ENT];

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NUM_ENT); k++) begin
                pal_act[k] <= '0;
                pal_shd[k] <= '0;
            end
            palette_ready <= 1'b1;
        end else begin
            if (frame_end) begin
                for (int k = 0; k < int'(NUM_ENT); k++) pal_act[k] <= pal_shd[k];
                palette_ready <= 1'b1;
            end
            if (palette_valid && palette_ready) begin
                for (int k = 0; k < int'(NUM_ENT); k++)
                    pal_shd[k] <= palette_in[k*COLOR_W +: COLOR_W];
                palette_ready <= 1'b0;
            end
        end
    end

    logic [COLOR_W-1:0] pix_c;

`ifdef VGA_COLOR_PIPELINE_TESTPATTERN_EN
    logic [2:0]  bar;
    logic [11:0] bar_rgb;
    assign bar     = 3'((32'(hc_d) * 32'd8) / H_ACTIVE);
    assign bar_rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`endif

    // Bin 0 and blanked/unready pixels are black; test bars override the lookup.
    always_comb begin
        pix_c = '0;
        if (act_d && rdy_d && (bin_data != '0)) pix_c = pal_act[bin_data - BIN_W'(1)];
`ifdef VGA_COLOR_PIPELINE_TESTPATTERN_EN
        if (act_d && tm_d) pix_c = COLOR_W'(bar_rgb);
`endif
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) video_out <= '0;
        else        video_out <= pix_c;
    end

endmodule
